// File: rtl/rv_wb_commit_arbiter.sv
// Packet-aware round-robin arbiter sharing the writeback port among commit sources; a grant stays
// locked to one source until its eop beat is accepted. Optional starvation boost: WB_ARB_STARVE_EN.
module rv_wb_commit_arbiter #(
  parameter int NUM_REQS     = 5,
  parameter int NW_BITS      = 2,
  parameter int NUM_THREADS  = 4,
  parameter int NR_BITS      = 5,
  parameter int DATAW        = 1 + NW_BITS + 32 + NUM_THREADS + NR_BITS + NUM_THREADS * 32,
  parameter int STARVE_LIMIT = 15,
  localparam int IDXW        = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  input  logic [NUM_REQS-1:0]       eop_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic                      eop_out,
  output logic [IDXW-1:0]           grant_idx_out,
  input  logic                      ready_out,
  output logic [0:0]                dbg_state,
  output logic [IDXW-1:0]           dbg_rr_ptr
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]          state;
  logic [IDXW-1:0]     owner;
  logic [IDXW-1:0]     rr_ptr;

  logic                load;
  logic                fire;
  logic                fire_eop;
  logic                has_grant;
  logic [IDXW-1:0]     grant_idx;
  logic [NUM_REQS-1:0] ready_vec;

  logic                rr_found;
  logic [IDXW-1:0]     rr_idx;
  logic [IDXW:0]       cand;

  logic                starved_found;
  logic [IDXW-1:0]     starved_idx;

  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

  // Handshake: a source beat transfers when valid_in[i] & ready_in[i]; the output beat transfers
  // when valid_out & ready_out. The output stage reloads whenever it is empty or being drained.
  assign load = ~valid_out | ready_out;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand = {1'b0, rr_ptr} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NUM_REQS)) begin
        cand = cand - (IDXW+1)'(NUM_REQS);
      end
      if (!rr_found && valid_in[cand[IDXW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[IDXW-1:0];
      end
    end
  end

`ifdef WB_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt [NUM_REQS];

  always_comb begin
    starved_found = 1'b0;
    starved_idx   = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!starved_found && valid_in[i] && (starve_cnt[i] == SW'(STARVE_LIMIT))) begin
        starved_found = 1'b1;
        starved_idx   = IDXW'(i);
      end
    end
  end

  // Counters saturate so a source that keeps waiting stays eligible for the boost.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (reset) begin
        starve_cnt[i] <= '0;
      end else if (valid_in[i] && ready_vec[i]) begin
        starve_cnt[i] <= '0;
      end else if (valid_in[i] && (starve_cnt[i] != SW'(STARVE_LIMIT))) begin
        starve_cnt[i] <= starve_cnt[i] + 1'b1;
      end
    end
  end
`else
  assign starved_found = 1'b0;
  assign starved_idx   = '0;
`endif

  // A lock holds the grant on its owner even while the owner is idle, so packets never interleave.
  always_comb begin
    grant_idx = rr_idx;
    has_grant = rr_found;
    if (state == LOCKED) begin
      grant_idx = owner;
      has_grant = 1'b1;
    end else if (starved_found) begin
      grant_idx = starved_idx;
      has_grant = 1'b1;
    end
  end

  always_comb begin
    ready_vec = '0;
    if (load && has_grant) begin
      ready_vec[grant_idx] = 1'b1;
    end
  end

  assign ready_in = ready_vec;
  assign fire     = |(valid_in & ready_vec);
  assign fire_eop = eop_in[grant_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out     <= 1'b0;
      data_out      <= '0;
      eop_out       <= 1'b0;
      grant_idx_out <= '0;
    end else if (load) begin
      valid_out <= fire;
      if (fire) begin
        data_out      <= data_in[grant_idx*DATAW +: DATAW];
        eop_out       <= fire_eop;
        grant_idx_out <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (fire) begin
      if (fire_eop) begin
        state  <= IDLE;
        rr_ptr <= (grant_idx == IDXW'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        state <= LOCKED;
        owner <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_rv_wb_commit_arbiter.sv
// Bench for rv_wb_commit_arbiter: directed vector table, a high-level arbitration model for random
// traffic, and (with WB_ARB_STARVE_EN) a starvation-boost sequence.
module tb_rv_wb_commit_arbiter;

  localparam int NUM_REQS     = 5;
  localparam int DATAW        = 1 + 2 + 32 + 4 + 5 + 4 * 32;
  localparam int STARVE_LIMIT = 3;
  localparam int IDXW         = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQS-1:0]       valid_in;
  logic [NUM_REQS*DATAW-1:0] data_in;
  logic [NUM_REQS-1:0]       eop_in;
  logic [NUM_REQS-1:0]       ready_in;
  logic                      valid_out;
  logic [DATAW-1:0]          data_out;
  logic                      eop_out;
  logic [IDXW-1:0]           grant_idx_out;
  logic                      ready_out;
  logic [0:0]                dbg_state;
  logic [IDXW-1:0]           dbg_rr_ptr;

  int n_vec = 0;
  int n_err = 0;

  rv_wb_commit_arbiter #(
    .NUM_REQS    (NUM_REQS),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .eop_in       (eop_in),
    .ready_in     (ready_in),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .eop_out      (eop_out),
    .grant_idx_out(grant_idx_out),
    .ready_out    (ready_out),
    .dbg_state    (dbg_state),
    .dbg_rr_ptr   (dbg_rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DATAW-1:0] pat(input int i);
    logic [255:0] t;
    t = {8{32'hC0DE0000 + 32'(i)}};
    return t[DATAW-1:0];
  endfunction

  // Reference model: arbitration state kept as plain integers.
  bit               m_sync = 0;
  bit               m_locked;
  int               m_owner;
  int               m_rr;
  bit               m_vout;
  bit               m_eop;
  int               m_idx;
  logic [DATAW-1:0] m_data;
  int               m_cnt [NUM_REQS];

  function automatic int pick(input logic [NUM_REQS-1:0] v);
    if (m_locked) return m_owner;
`ifdef WB_ARB_STARVE_EN
    for (int i = 0; i < NUM_REQS; i++) begin
      if (v[i] && m_cnt[i] == STARVE_LIMIT) return i;
    end
`endif
    for (int k = 0; k < NUM_REQS; k++) begin
      if (v[(m_rr + k) % NUM_REQS]) return (m_rr + k) % NUM_REQS;
    end
    return -1;
  endfunction

  task automatic step(input logic r, input logic [NUM_REQS-1:0] v, input logic [NUM_REQS-1:0] e,
                      input logic ro, output logic [NUM_REQS-1:0] rdy_seen);
    int g;
    bit ld;
    bit fr;
    logic [NUM_REQS-1:0] exp_rdy;
    rst = r; valid_in = v; eop_in = e; ready_out = ro;
    #2;
    ld = !m_vout || ro;
    g  = pick(v);
    exp_rdy = (ld && g >= 0) ? NUM_REQS'(1 << g) : '0;
    rdy_seen = ready_in;
    if (m_sync) chk("ready_in", ready_in, exp_rdy);
    fr = ld && g >= 0 && v[g];
    if (r) begin
      m_sync = 1; m_locked = 0; m_owner = 0; m_rr = 0;
      m_vout = 0; m_eop = 0; m_idx = 0; m_data = '0;
      for (int i = 0; i < NUM_REQS; i++) m_cnt[i] = 0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (fr && i == g) m_cnt[i] = 0;
        else if (v[i] && m_cnt[i] < STARVE_LIMIT) m_cnt[i]++;
      end
      if (ld) begin
        m_vout = fr;
        if (fr) begin
          m_idx = g; m_eop = e[g]; m_data = data_in[g*DATAW +: DATAW];
        end
      end
      if (fr) begin
        if (e[g]) begin
          m_locked = 0; m_rr = (g + 1) % NUM_REQS;
        end else begin
          m_locked = 1; m_owner = g;
        end
      end
    end
    @(posedge clk); #1;
    if (m_sync) begin
      chk("valid_out", valid_out, m_vout);
      if (m_vout || r) begin
        chk("grant_idx_out", grant_idx_out, m_idx);
        chk("eop_out", eop_out, m_eop);
        chk("data_out", data_out, m_data);
      end
      chk("state", dbg_state, m_locked);
      chk("rr_ptr", dbg_rr_ptr, m_rr);
    end
  endtask

  typedef struct {
    logic                rst;
    logic [NUM_REQS-1:0] v;
    logic [NUM_REQS-1:0] e;
    logic                ro;
    logic [NUM_REQS-1:0] exp_rdy;
    logic                exp_vout;
    logic [IDXW-1:0]     exp_idx;
    logic                exp_eop;
  } vec_t;

  vec_t tbl [26];
  logic [NUM_REQS-1:0] rs;
  logic [NUM_REQS*DATAW+31:0] tmp;

  initial begin
    tbl[0]  = '{1'b1, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0, 1'b1};
    tbl[2]  = '{1'b0, 5'b11111, 5'b11111, 1'b1, 5'b00010, 1'b1, 3'd1, 1'b1};
    tbl[3]  = '{1'b0, 5'b11111, 5'b11111, 1'b1, 5'b00100, 1'b1, 3'd2, 1'b1};
    tbl[4]  = '{1'b0, 5'b11111, 5'b11111, 1'b1, 5'b01000, 1'b1, 3'd3, 1'b1};
    tbl[5]  = '{1'b0, 5'b11111, 5'b11111, 1'b1, 5'b10000, 1'b1, 3'd4, 1'b1};
    tbl[6]  = '{1'b0, 5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0, 1'b1};
    tbl[7]  = '{1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0};
    tbl[8]  = '{1'b0, 5'b00101, 5'b00001, 1'b1, 5'b00100, 1'b1, 3'd2, 1'b0};
    tbl[9]  = '{1'b0, 5'b00101, 5'b00001, 1'b1, 5'b00100, 1'b1, 3'd2, 1'b0};
    tbl[10] = '{1'b0, 5'b00101, 5'b00101, 1'b1, 5'b00100, 1'b1, 3'd2, 1'b1};
    tbl[11] = '{1'b0, 5'b00001, 5'b00001, 1'b1, 5'b00001, 1'b1, 3'd0, 1'b1};
    tbl[12] = '{1'b0, 5'b00010, 5'b00010, 1'b0, 5'b00000, 1'b1, 3'd0, 1'b1};
    tbl[13] = '{1'b0, 5'b00010, 5'b00010, 1'b0, 5'b00000, 1'b1, 3'd0, 1'b1};
    tbl[14] = '{1'b0, 5'b00010, 5'b00010, 1'b0, 5'b00000, 1'b1, 3'd0, 1'b1};
    tbl[15] = '{1'b0, 5'b00010, 5'b00010, 1'b0, 5'b00000, 1'b1, 3'd0, 1'b1};
    tbl[16] = '{1'b0, 5'b00010, 5'b00010, 1'b1, 5'b00010, 1'b1, 3'd1, 1'b1};
    tbl[17] = '{1'b0, 5'b00010, 5'b00000, 1'b1, 5'b00010, 1'b1, 3'd1, 1'b0};
    tbl[18] = '{1'b0, 5'b01000, 5'b01000, 1'b1, 5'b00010, 1'b0, 3'd0, 1'b0};
    tbl[19] = '{1'b0, 5'b01000, 5'b01000, 1'b1, 5'b00010, 1'b0, 3'd0, 1'b0};
    tbl[20] = '{1'b0, 5'b01010, 5'b00010, 1'b1, 5'b00010, 1'b1, 3'd1, 1'b1};
    tbl[21] = '{1'b0, 5'b01000, 5'b01000, 1'b1, 5'b01000, 1'b1, 3'd3, 1'b1};
    tbl[22] = '{1'b0, 5'b10000, 5'b00000, 1'b1, 5'b10000, 1'b1, 3'd4, 1'b0};
    tbl[23] = '{1'b1, 5'b10001, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0};
    tbl[24] = '{1'b0, 5'b10001, 5'b10001, 1'b1, 5'b00001, 1'b1, 3'd0, 1'b1};
    tbl[25] = '{1'b0, 5'b10001, 5'b10001, 1'b1, 5'b10000, 1'b1, 3'd4, 1'b1};

    // Clock/reset block
    rst = 1'b1; valid_in = '0; eop_in = '0; ready_out = 1'b1;
    for (int i = 0; i < NUM_REQS; i++) data_in[i*DATAW +: DATAW] = pat(i);
    repeat (2) @(posedge clk);
    #1;

`ifndef WB_ARB_STARVE_EN
    for (int i = 0; i < 26; i++) begin
      rst = tbl[i].rst; valid_in = tbl[i].v; eop_in = tbl[i].e; ready_out = tbl[i].ro;
      #2;
      chk($sformatf("v%0d_ready_in", i), ready_in, tbl[i].exp_rdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid_out", i), valid_out, tbl[i].exp_vout);
      if (tbl[i].exp_vout || tbl[i].rst) begin
        chk($sformatf("v%0d_grant_idx", i), grant_idx_out, tbl[i].exp_idx);
        chk($sformatf("v%0d_eop_out", i), eop_out, tbl[i].exp_eop);
        chk($sformatf("v%0d_data_out", i), data_out, tbl[i].rst ? '0 : pat(int'(tbl[i].exp_idx)));
      end
      if (tbl[i].rst) begin
        chk($sformatf("v%0d_rr_ptr", i), dbg_rr_ptr, 3'd0);
        chk($sformatf("v%0d_state", i), dbg_state, 1'b0);
      end
    end
`else
    // Starvation boost: src3 waits through a src0 packet, then wins over round-robin choice src1.
    step(1'b1, 5'b00000, 5'b00000, 1'b1, rs);
    step(1'b0, 5'b01001, 5'b01000, 1'b1, rs); chk("starve_c0", rs, 5'b00001);
    step(1'b0, 5'b01001, 5'b01000, 1'b1, rs); chk("starve_c1", rs, 5'b00001);
    step(1'b0, 5'b01011, 5'b01010, 1'b1, rs); chk("starve_c2", rs, 5'b00001);
    step(1'b0, 5'b01011, 5'b01011, 1'b1, rs); chk("starve_c3", rs, 5'b00001);
    step(1'b0, 5'b01010, 5'b01010, 1'b1, rs); chk("starve_c4", rs, 5'b01000);
    step(1'b0, 5'b00010, 5'b00010, 1'b1, rs); chk("starve_c5", rs, 5'b00010);
`endif

    // Random traffic against the model
    step(1'b1, 5'b00000, 5'b00000, 1'b1, rs);
    for (int n = 0; n < 1500; n++) begin
      for (int w = 0; w < NUM_REQS * DATAW; w += 32) tmp[w +: 32] = $urandom;
      data_in = tmp[NUM_REQS*DATAW-1:0];
      step($urandom_range(0, 199) == 0, NUM_REQS'($urandom), NUM_REQS'($urandom),
           $urandom_range(0, 3) != 0, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
